serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per cycle, LSB first.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic bit_diff;
    logic bit_borrow;

    full_subtractor u_full_subtractor (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .borrow_in (bw_q),
        .diff      (bit_diff),
        .borrow_out(bit_borrow)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        bw_d         = bw_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bw_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Operands shift right so the next bit is always at [0];
                // results enter at the MSB and settle into place after WIDTH shifts.
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                bw_d   = bit_borrow;
                diff_d = {bit_diff, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    borrow_out_d = bit_borrow;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            bw_q         <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            bw_q         <= bw_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH 8 and 4) and full_subtractor.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    logic fx, fy, fb, fd, fbo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4)
    );

    full_subtractor u_fs (
        .a(fx), .b(fy), .borrow_in(fb), .diff(fd), .borrow_out(fbo)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    vec_t vecs[7];

    // Reference: plain integer subtraction reduced modulo 2^w.
    function automatic int ref_diff(input int x, input int y, input int bw, input int w);
        int m;
        m = 1 << w;
        return (((x - y - bw) % m) + m) % m;
    endfunction

    function automatic int ref_bout(input int x, input int y, input int bw);
        return (x < y + bw) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done8) break;
        end
        if (!done8) begin
            checks++;
            errors++;
            $display("FAIL done8_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       output logic [7:0] od, output logic ob, output int lat);
        @(negedge clk);
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat);
        od = diff8;
        ob = bout8;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                       output logic [3:0] od, output logic ob, output int lat);
        @(negedge clk);
        a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done4) break;
        end
        if (!done4) begin
            checks++;
            errors++;
            $display("FAIL done4_timeout: got no done, expected done within 40 cycles");
        end
        od = diff4;
        ob = bout4;
    endtask

    initial begin
        logic [7:0] d8;
        logic [3:0] d4;
        logic       bo;
        int         lat, nbusy, bad, ndone, prev_done, mism;
        logic [7:0] ra, rb;
        logic       rbin;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        fx = 1'b0; fy = 1'b0; fb = 1'b0;

        // full_subtractor truth table
        for (int i = 0; i < 8; i++) begin
            fx = i[2]; fy = i[1]; fb = i[0];
            #1;
            check($sformatf("fs_diff_%0d", i), int'(fd),
                  ref_diff(int'(fx), int'(fy), int'(fb), 1));
            check($sformatf("fs_bout_%0d", i), int'(fbo),
                  ref_bout(int'(fx), int'(fy), int'(fb)));
        end

        // Reset values, then rst dominating a concurrent start
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_diff", int'(diff8), 0);
        check("rst_bout", int'(bout8), 0);

        // First start accepted on the first edge after rst deasserts
        rst = 1'b0;
        @(negedge clk);
        check("first_start_busy", int'(busy8), 1);
        start8 = 1'b0;
        wait_done8(lat);
        check("first_latency", lat, 8);
        check("first_diff", int'(diff8), 8'h02);
        check("first_bout", int'(bout8), 0);
        check("first_busy_in_done", int'(busy8), 0);

        // Hold result until next start
        repeat (3) @(negedge clk);
        check("hold_diff", int'(diff8), 8'h02);
        check("hold_done_low", int'(done8), 0);

        // Directed vector table
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, d8, bo, lat);
            check($sformatf("vec%0d_diff", i), int'(d8), int'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), int'(bo), int'(vecs[i].exp_bout));
            check($sformatf("vec%0d_lat", i), lat, 8);
        end

        // Start pulsed during RUN is ignored
        @(negedge clk);
        a8 = 8'hA0; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nbusy = int'(busy8);
        @(negedge clk);
        nbusy += int'(busy8);
        @(negedge clk);
        nbusy += int'(busy8);
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nbusy += int'(busy8);
        for (int i = 0; i < 40 && !done8; i++) begin
            @(negedge clk);
            nbusy += int'(busy8);
        end
        check("ign_done_seen", int'(done8), 1);
        check("ign_diff", int'(diff8), 8'h90);
        check("ign_bout", int'(bout8), 0);
        check("ign_busy_cycles", nbusy, 8);

        // Reset asserted mid-RUN discards the partial result
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy8), 0);
        check("midrst_done", int'(done8), 0);
        check("midrst_diff", int'(diff8), 0);
        check("midrst_bout", int'(bout8), 0);
        op8(8'h10, 8'h01, 1'b0, d8, bo, lat);
        check("postrst_diff", int'(d8), 8'h0F);
        check("postrst_bout", int'(bo), 0);

        // start held high across DONE: back-to-back operations
        repeat (2) @(negedge clk);
        a8 = 8'h37; b8 = 8'h5A; bin8 = 1'b0; start8 = 1'b1;
        bad = 0; ndone = 0; prev_done = -1; mism = 0;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            if ((busy8 ^ done8) !== 1'b1) bad++;
            if (done8) begin
                if (prev_done >= 0 && (i - prev_done) != 9) mism++;
                if (diff8 !== 8'hDD || bout8 !== 1'b1) mism++;
                prev_done = i;
                ndone++;
            end
        end
        start8 = 1'b0;
        check("b2b_busy_xor_done", bad, 0);
        check("b2b_done_count", ndone, 3);
        check("b2b_spacing_and_result", mism, 0);
        wait_done8(lat);
        @(negedge clk);
        check("b2b_idle_after", int'(busy8 | done8), 0);

        // Randomized WIDTH=8 against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            op8(ra, rb, rbin, d8, bo, lat);
            check($sformatf("rnd%0d_diff(a=%0h,b=%0h,bi=%0d)", i, ra, rb, rbin), int'(d8),
                  ref_diff(int'(ra), int'(rb), int'(rbin), 8));
            check($sformatf("rnd%0d_bout", i), int'(bo), ref_bout(int'(ra), int'(rb), int'(rbin)));
        end

        // Exhaustive WIDTH=4
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(x), 4'(y), 1'(c), d4, bo, lat);
                    check($sformatf("w4_%0d_%0d_%0d_diff", x, y, c), int'(d4), ref_diff(x, y, c, 4));
                    check($sformatf("w4_%0d_%0d_%0d_bout", x, y, c), int'(bo), ref_bout(x, y, c));
                    if (x == 0 && y == 0 && c == 0) check("w4_latency", lat, 4);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
